// File: rtl/fpu_pkg.sv
// Shared fp16 types and field widths for the FPU add/sub datapath.
package fpu_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MANT_W = 10;
    localparam int unsigned SIG_W  = 11;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp16_t;

endpackage

// File: rtl/fpu_sticky_shifter.sv
// Combinational right shifter for significand alignment, with optional guard/round/sticky
// collection (enabled by FPU_ALIGN_GRS_EN).
module fpu_sticky_shifter
    import fpu_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    input  logic [EXP_W-1:0] shamt_i,
`ifdef FPU_ALIGN_GRS_EN
    output logic [2:0]       grs_o,
`endif
    output logic [SIG_W-1:0] sig_o
);

    // Enough zero padding that any 5-bit shift lands every significand bit below the LSB.
    localparam int unsigned PadW  = (1 << EXP_W) - 1;
    localparam int unsigned WideW = SIG_W + PadW;

    logic [WideW-1:0] wide;

    always_comb begin
        wide  = {sig_i, {PadW{1'b0}}} >> shamt_i;
        sig_o = wide[PadW +: SIG_W];
    end

`ifdef FPU_ALIGN_GRS_EN
    always_comb begin
        grs_o = {wide[PadW-1], wide[PadW-2], |wide[PadW-3:0]};
    end
`else
    logic unused_low;
    assign unused_low = ^wide[PadW-1:0];
`endif

endmodule

// File: rtl/fpu_add_sub_aligner.sv
// Aligns the smaller fp16 operand to the larger operand's exponent, one-cycle registered.
// Optional grs output is enabled by FPU_ALIGN_GRS_EN.
module fpu_add_sub_aligner
    import fpu_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  inValid,
    input  fp16_t largeNum,
    input  fp16_t smallNum,
    output logic  outValid,
`ifdef FPU_ALIGN_GRS_EN
    output fp16_t alignedSmallNum,
    output logic [2:0] grs
`else
    output fp16_t alignedSmallNum
`endif
);

    logic [EXP_W-1:0] shamt;
    logic [SIG_W-1:0] sig_in;
    logic [SIG_W-1:0] sig_shifted;
    fp16_t            aligned_d, aligned_q;
    logic             valid_q;

    // Raw exponent difference; subnormals deliberately keep exponent 0.
    always_comb begin
        shamt  = (largeNum.exp > smallNum.exp) ? (largeNum.exp - smallNum.exp) : '0;
        sig_in = {|smallNum.exp, smallNum.mant};
    end

`ifdef FPU_ALIGN_GRS_EN
    logic [2:0] grs_d, grs_q;

    fpu_sticky_shifter u_shifter (
        .sig_i   (sig_in),
        .shamt_i (shamt),
        .grs_o   (grs_d),
        .sig_o   (sig_shifted)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grs_q <= '0;
        end else if (inValid) begin
            grs_q <= grs_d;
        end
    end

    assign grs = grs_q;
`else
    fpu_sticky_shifter u_shifter (
        .sig_i   (sig_in),
        .shamt_i (shamt),
        .sig_o   (sig_shifted)
    );
`endif

    always_comb begin
        aligned_d      = '0;
        aligned_d.sign = smallNum.sign;
        aligned_d.exp  = largeNum.exp;
        aligned_d.mant = sig_shifted[MANT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            aligned_q <= '0;
        end else begin
            valid_q <= inValid;
            if (inValid) begin
                aligned_q <= aligned_d;
            end
        end
    end

    assign outValid        = valid_q;
    assign alignedSmallNum = aligned_q;

    // largeNum's sign and the shifted hidden bit never reach an output.
    logic unused_bits;
    assign unused_bits = largeNum.sign ^ sig_shifted[SIG_W-1];

endmodule

// File: tb/tb_fpu_add_sub_aligner.sv
// Scoreboard bench for fpu_add_sub_aligner: directed vectors plus random operands against an
// arithmetic reference model.
module tb_fpu_add_sub_aligner;
    import fpu_pkg::*;

    logic  clock;
    logic  reset_n;
    logic  inValid;
    fp16_t largeNum;
    fp16_t smallNum;
    logic  outValid;
    fp16_t alignedSmallNum;
`ifdef FPU_ALIGN_GRS_EN
    logic [2:0] grs;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  grs;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   have_last;

    fpu_add_sub_aligner dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .inValid         (inValid),
        .largeNum        (largeNum),
        .smallNum        (smallNum),
        .outValid        (outValid),
`ifdef FPU_ALIGN_GRS_EN
        .alignedSmallNum (alignedSmallNum),
        .grs             (grs)
`else
        .alignedSmallNum (alignedSmallNum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [15:0] l, input logic [15:0] s);
        exp_t r;
        int le, se, sig, d, mant;
        le   = int'(l[14:10]);
        se   = int'(s[14:10]);
        sig  = ((se != 0) ? 1024 : 0) + int'(s[9:0]);
        d    = (le > se) ? le - se : 0;
        mant = (sig >> d) % 1024;
        r.data   = {s[15], l[14:10], 10'(mant)};
        r.grs[2] = (d >= 1) ? ((sig >> (d - 1)) % 2 == 1) : 1'b0;
        r.grs[1] = (d >= 2) ? ((sig >> (d - 2)) % 2 == 1) : 1'b0;
        r.grs[0] = (d >= 3) ? ((sig % (1 << (d - 2))) != 0) : 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_valid"}, {15'd0, outValid}, 16'd0);
        check({name, "_data"}, alignedSmallNum, 16'd0);
`ifdef FPU_ALIGN_GRS_EN
        check({name, "_grs"}, {13'd0, grs}, 16'd0);
`endif
    endtask

    // Inputs change just after the rising edge; the next rising edge captures them.
    task automatic issue(input logic [15:0] l, input logic [15:0] s);
        @(posedge clock);
        #1;
        inValid  = 1'b1;
        largeNum = l;
        smallNum = s;
        exp_q.push_back(model(l, s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            inValid  = 1'b0;
            largeNum = 16'($urandom);
            smallNum = 16'($urandom);
        end
    endtask

    // Monitor: pops on every valid output, checks hold behaviour when idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (outValid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid: got outValid=1 expected no pending result");
                    end else begin
                        e = exp_q.pop_front();
                        check("result_data", alignedSmallNum, e.data);
`ifdef FPU_ALIGN_GRS_EN
                        check("result_grs", {13'd0, grs}, {13'd0, e.grs});
`endif
                        last_exp  = e;
                        have_last = 1'b1;
                    end
                end else if (have_last) begin
                    check("hold_data", alignedSmallNum, last_exp.data);
`ifdef FPU_ALIGN_GRS_EN
                    check("hold_grs", {13'd0, grs}, {13'd0, last_exp.grs});
`endif
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        have_last = 1'b0;
        reset_n   = 1'b0;
        inValid   = 1'b0;
        largeNum  = 16'h0;
        smallNum  = 16'h0;
        #1;
        check_zero_outputs("reset_state");
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        last_exp.data = 16'h0;
        last_exp.grs  = 3'b0;
        have_last     = 1'b1;
        idle(2);

        issue(16'h0000, 16'h0000);
        issue(16'b1_00010_0111111111, 16'b0_00000_0111111111);
        issue(16'b1_10111_0000000000, 16'b1_10000_1000000000);
        issue(16'b0_11110_0000000000, 16'b0_00001_1111111111);
        idle(2);
        // smallNum exponent larger than largeNum's: no shift
        issue(16'b0_00011_0101010101, 16'b1_01000_1100110011);
        issue(16'b1_11111_1111111111, 16'b0_11111_0000000001);
        idle(1);

        // Three back-to-back then idle, data must hold
        issue(16'b0_10101_0000000000, 16'b0_10011_1010101011);
        issue(16'b0_01110_0000000000, 16'b1_00100_0110011001);
        issue(16'b1_01100_0000000000, 16'b0_01011_1111111111);
        idle(3);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            else issue(16'($urandom), 16'($urandom));
        end
        idle(3);

        // Asynchronous reset mid-stream after a capture
        issue(16'b0_11000_0000000000, 16'b0_10010_1111000011);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        exp_q.delete();
        last_exp.data = 16'h0;
        last_exp.grs  = 3'b0;
        @(posedge clock);
        #1;
        check_zero_outputs("reset_held");
        #2;
        reset_n = 1'b1;
        idle(2);
        issue(16'b0_00101_0000000000, 16'b1_00001_0000000001);
        issue(16'b0_10000_0000000000, 16'b0_00000_1000000000);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
